ram_divider: RTL and testbench

Sequential restoring divider that sits on the read side of the multiplier datapath's 8×8 result RAM. On `start` it fetches an 8-bit product from a RAM address and divides it by a 4-bit divisor. It returns an 8-bit quotient and a 4-bit remainder, so stored products can be checked against or decomposed into the register-file operands that produced them. A start/busy/done handshake controls each operation, and the block exposes its state code for board LEDs.

---
 rtl/ram_divider_if.sv | 26 ++
 rtl/ram_divider.sv | 117 +++++++++++
 tb/tb_ram_divider.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_divider_if.sv
// rtl/ram_divider_if.sv - start/busy/done handshake, RAM read and result bundle for ram_divider
// master: requester side (drives start/adr_in/divisor and returns RAM read data)
// slave : divider side (drives RAM address, results, status and state code)
interface ram_divider_if;
    logic       start;
    logic [2:0] adr_in;
    logic [3:0] divisor;
    logic [2:0] ram_adr;
    logic [7:0] ram_data;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] st_out;

    modport master (
        output start, adr_in, divisor, ram_data,
        input  ram_adr, quotient, remainder, busy, done, err, st_out
    );

    modport slave (
        input  start, adr_in, divisor, ram_data,
        output ram_adr, quotient, remainder, busy, done, err, st_out
    );
endinterface

// File: rtl/ram_divider.sv
// rtl/ram_divider.sv - sequential restoring divider reading its 8-bit dividend from the result RAM
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset
//   bus - ram_divider_if.slave: start/adr_in/divisor request, ram_adr/ram_data RAM read,
//         quotient/remainder/err results, busy/done handshake, st_out state code
module ram_divider (
    input  logic          clk,
    input  logic          rst,
    ram_divider_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [2:0] adr_q;
    logic [3:0] div_q;
    logic [7:0] dividend;
    // After each restore the partial remainder is below the divisor, so only
    // 4 bits are stored; the 5th bit exists only in the shifted value.
    logic [3:0] part_rem;
    logic [2:0] cnt;
    // Quotient bits collected so far; the 8th bit goes straight into quotient_q.
    logic [6:0] q_acc;
    logic [7:0] quotient_q;
    logic [3:0] rem_q;
    logic       err_q;

    logic [4:0] part_shift;
    logic [4:0] part_next;
    logic       q_bit;

    always_comb begin
        part_shift = {part_rem, dividend[7]};
        q_bit      = (part_shift >= {1'b0, div_q});
        part_next  = q_bit ? (part_shift - {1'b0, div_q}) : part_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (bus.start) state_next = S_LOAD;
            S_LOAD: state_next = (div_q == 4'd0) ? S_DONE : S_DIV;
            S_DIV:  if (cnt == 3'd7) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adr_q      <= 3'd0;
            div_q      <= 4'd0;
            dividend   <= 8'd0;
            part_rem   <= 4'd0;
            cnt        <= 3'd0;
            q_acc      <= 7'd0;
            quotient_q <= 8'd0;
            rem_q      <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        adr_q <= bus.adr_in;
                        div_q <= bus.divisor;
                    end
                end
                S_LOAD: begin
                    dividend <= bus.ram_data;
                    part_rem <= 4'd0;
                    cnt      <= 3'd0;
                    q_acc    <= 7'd0;
                    if (div_q == 4'd0) begin
                        quotient_q <= 8'hFF;
                        rem_q      <= bus.ram_data[3:0];
                        err_q      <= 1'b1;
                    end
                end
                S_DIV: begin
                    part_rem <= part_next[3:0];
                    dividend <= {dividend[6:0], 1'b0};
                    q_acc    <= {q_acc[5:0], q_bit};
                    cnt      <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        quotient_q <= {q_acc, q_bit};
                        rem_q      <= part_next[3:0];
                        err_q      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_adr   = adr_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = rem_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state == S_LOAD) || (state == S_DIV);
    assign bus.done      = (state == S_DONE);
    assign bus.st_out    = {1'b0, state};
endmodule

// File: tb/tb_ram_divider.sv
// tb/tb_ram_divider.sv - self-checking bench for ram_divider
module tb_ram_divider;
    logic clk;
    logic rst;
    ram_divider_if bus ();

    ram_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [0:7];
    always_comb bus.ram_data = ram[bus.ram_adr];

    int checks;
    int errors;

    function automatic void model(input logic [7:0] dvd, input logic [3:0] dvs,
                                  output logic [7:0] q, output logic [3:0] r, output logic e);
        if (dvs == 4'd0) begin
            q = 8'hFF;
            r = dvd[3:0];
            e = 1'b1;
        end else begin
            q = 8'(int'(dvd) / int'(dvs));
            r = 4'(int'(dvd) % int'(dvs));
            e = 1'b0;
        end
    endfunction

    // Issues start before edge E0 and returns the edge index (relative to E0)
    // after which done was first observed, or -1 on timeout.
    task automatic run_op(input logic [2:0] adr, input logic [3:0] dvs, output int lat);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.adr_in  = adr;
        bus.divisor = dvs;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.st_out, bus.quotient, bus.remainder, bus.busy, bus.done, bus.err, bus.ram_adr} !== 22'd0) begin
            errors++;
            $display("FAIL reset_state: got st=%0d q=%0h r=%0h busy=%b done=%b err=%b adr=%0d, want all zero",
                     bus.st_out, bus.quotient, bus.remainder, bus.busy, bus.done, bus.err, bus.ram_adr);
        end
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic [2:0] adrs [0:4];
        logic [3:0] dvss [0:4];
        logic [7:0] dvds [0:4];
        logic [7:0] eq [0:4];
        logic [3:0] er [0:4];
        int lat;
        adrs = '{3'd3, 3'd5, 3'd0, 3'd7, 3'd1};
        dvss = '{4'd6, 4'd14, 4'd15, 4'd1, 4'd15};
        dvds = '{8'h2A, 8'hE1, 8'hFF, 8'h9C, 8'h0E};
        eq   = '{8'd7, 8'd16, 8'd17, 8'h9C, 8'd0};
        er   = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd14};
        for (int i = 0; i < 5; i++) begin
            ram[adrs[i]] = dvds[i];
            run_op(adrs[i], dvss[i], lat);
            checks++;
            if (lat !== 9 || bus.quotient !== eq[i] || bus.remainder !== er[i] || bus.err !== 1'b0) begin
                errors++;
                $display("FAIL vector_%0d: got lat=%0d q=%0d r=%0d err=%b, want lat=9 q=%0d r=%0d err=0",
                         i, lat, bus.quotient, bus.remainder, bus.err, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        ram[2] = 8'h35;
        run_op(3'd2, 4'd0, lat);
        checks++;
        if (lat !== 1 || bus.quotient !== 8'hFF || bus.remainder !== 4'd5 || bus.err !== 1'b1) begin
            errors++;
            $display("FAIL div_zero: got lat=%0d q=%0h r=%0d err=%b, want lat=1 q=ff r=5 err=1",
                     lat, bus.quotient, bus.remainder, bus.err);
        end
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b1 || bus.quotient !== 8'hFF) begin
            errors++;
            $display("FAIL div_zero_hold: got q=%0h err=%b, want q=ff err=1", bus.quotient, bus.err);
        end
        ram[4] = 8'd100;
        run_op(3'd4, 4'd7, lat);
        checks++;
        if (lat !== 9 || bus.quotient !== 8'd14 || bus.remainder !== 4'd2 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got lat=%0d q=%0d r=%0d err=%b, want lat=9 q=14 r=2 err=0",
                     lat, bus.quotient, bus.remainder, bus.err);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        bit seen_busy_low;
        ram[6] = 8'd200;
        ram[1] = 8'd50;
        @(negedge clk);
        bus.start = 1'b1; bus.adr_in = 3'd6; bus.divisor = 4'd9;
        @(posedge clk);                      // E0
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);           // E1..E3
        @(negedge clk);
        bus.start = 1'b1; bus.adr_in = 3'd1; bus.divisor = 4'd3;
        @(posedge clk);                      // E4
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.ram_adr !== 3'd6 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_start_adr: got ram_adr=%0d busy=%b, want ram_adr=6 busy=1", bus.ram_adr, bus.busy);
        end
        lat = -1;
        for (int n = 5; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) begin lat = n; break; end
        end
        checks++;
        if (lat !== 9 || bus.quotient !== 8'd22 || bus.remainder !== 4'd2 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_result: got lat=%0d q=%0d r=%0d, want lat=9 q=22 r=2",
                     lat, bus.quotient, bus.remainder);
        end
        seen_busy_low = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) seen_busy_low = 1'b0;
        end
        checks++;
        if (seen_busy_low !== 1'b1 || bus.st_out !== 3'd0) begin
            errors++;
            $display("FAIL ignore_start_not_queued: got st=%0d idle_ok=%b, want st=0 idle_ok=1", bus.st_out, seen_busy_low);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        bit no_done;
        ram[3] = 8'h2A;
        @(negedge clk);
        bus.start = 1'b1; bus.adr_in = 3'd3; bus.divisor = 4'd6;
        @(posedge clk);                      // E0
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);           // E1..E4
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);                      // E5
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.st_out, bus.quotient, bus.remainder, bus.busy, bus.done, bus.err, bus.ram_adr} !== 22'd0) begin
            errors++;
            $display("FAIL mid_reset_state: got st=%0d q=%0h r=%0h busy=%b done=%b err=%b adr=%0d, want all zero",
                     bus.st_out, bus.quotient, bus.remainder, bus.busy, bus.done, bus.err, bus.ram_adr);
        end
        no_done = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.st_out !== 3'd0) no_done = 1'b0;
        end
        checks++;
        if (no_done !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_no_done: got quiet=%b, want quiet=1", no_done);
        end
        ram[7] = 8'd123;
        run_op(3'd7, 4'd10, lat);
        checks++;
        if (lat !== 9 || bus.quotient !== 8'd12 || bus.remainder !== 4'd3 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_restart: got lat=%0d q=%0d r=%0d err=%b, want lat=9 q=12 r=3 err=0",
                     lat, bus.quotient, bus.remainder, bus.err);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [2:0] a;
        logic [3:0] d;
        logic [7:0] eq;
        logic [3:0] er;
        logic ee;
        int elat;
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < 8; k++) ram[k] = 8'($urandom);
            a = 3'($urandom);
            d = 4'($urandom_range(0, 15));
            model(ram[a], d, eq, er, ee);
            elat = (d == 4'd0) ? 1 : 9;
            run_op(a, d, lat);
            checks++;
            if (lat !== elat || bus.quotient !== eq || bus.remainder !== er || bus.err !== ee) begin
                errors++;
                $display("FAIL random_%0d: dvd=%0d dvs=%0d got lat=%0d q=%0d r=%0d err=%b, want lat=%0d q=%0d r=%0d err=%b",
                         i, ram[a], d, lat, bus.quotient, bus.remainder, bus.err, elat, eq, er, ee);
            end
        end
    endtask

    task automatic test_sweep();
        int lat;
        int bad;
        bad = 0;
        for (int dvd = 0; dvd < 256; dvd++) begin
            for (int dvs = 1; dvs < 16; dvs++) begin
                ram[dvd % 8] = 8'(dvd);
                run_op(3'(dvd % 8), 4'(dvs), lat);
                checks++;
                if (lat !== 9 || bus.err !== 1'b0 ||
                    int'(bus.quotient) * dvs + int'(bus.remainder) != dvd ||
                    int'(bus.remainder) >= dvs) begin
                    errors++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL sweep: dvd=%0d dvs=%0d got lat=%0d q=%0d r=%0d err=%b, want q*dvs+r=dvd r<dvs err=0",
                                 dvd, dvs, lat, bus.quotient, bus.remainder, bus.err);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.adr_in = 3'd0;
        bus.divisor = 4'd0;
        for (int k = 0; k < 8; k++) ram[k] = 8'd0;
        test_reset();
        test_vectors();
        test_div_zero();
        test_ignore_start();
        test_mid_reset();
        test_random();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
